// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
//   UART transmit serializer acting as the dequeue-side reader of the TX FIFO.
//   Each word is requested with a one-cycle fifo_rd_req pulse, taken from the
//   FIFO's registered output one cycle later, and sent start / data LSB-first /
//   [parity] / stop on tx.
//
//   Build option: define UART_TX_PARITY_EN to insert an even-parity bit
//   between the data bits and the stop bit(s).
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   enable       level-sensitive permission to start new frames
//   fifo_dout    FIFO dequeue data, valid the cycle after fifo_rd_req
//   fifo_empty   FIFO empty flag
//   fifo_rd_req  one-cycle dequeue pulse per word
//   tx           serial line, idle high, driven from a flop
//   busy         high whenever the FSM is not idle
//   tx_done      one-cycle pulse on the last clk of the final stop bit
//
// state  | meaning
// IDLE   | line high, waiting for enable and a non-empty FIFO
// REQ    | fifo_rd_req asserted for one cycle
// LOAD   | FIFO output captured into the shift register
// START  | start bit (tx low)
// DATA   | data bits, LSB first
// PARITY | even-parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit(s); may chain straight into REQ
module uart_tx_fifo_reader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_req,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_nxt;
  logic [BW-1:0]        baud, baud_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 tx_nxt;
  logic                 baud_end;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  // The shift register is consumed during DATA, so parity is taken from the
  // word as it is loaded.
  always_ff @(posedge clk) begin
    if (reset)
      parity_bit <= 1'b0;
    else if (state == LOAD)
      parity_bit <= ^fifo_dout;
  end
`endif

  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      baud  <= baud_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      tx    <= tx_nxt;
    end
  end

  // idx counts data bits in DATA and stop bits in STOP, so the baud counter
  // never has to span more than one bit time.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    idx_nxt   = idx;
    shift_nxt = shift;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty)
          state_nxt = REQ;
      end
      REQ: state_nxt = LOAD;
      LOAD: begin
        shift_nxt = fifo_dout;
        baud_nxt  = '0;
        idx_nxt   = '0;
        state_nxt = START;
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          idx_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          if (idx == DATA_LAST) begin
            idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          baud_nxt = baud + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_nxt  = '0;
          idx_nxt   = '0;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud + BW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (idx == STOP_LAST) begin
            idx_nxt   = '0;
            state_nxt = (enable && !fifo_empty) ? REQ : IDLE;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          baud_nxt = baud + BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx is computed from the next-state values so the flop presents the new
  // bit in the same cycle the FSM enters that bit.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt = parity_bit;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  assign fifo_rd_req = (state == REQ);
  assign busy        = (state != IDLE);
  assign tx_done     = (state == STOP) && baud_end && (idx == STOP_LAST);

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
- UART transmit serializer that drains the team's transmit FIFO. It acts as the reader on the FIFO's dequeue side.
- It requests one word at a time, captures the registered FIFO output, and shifts it onto the serial line as an 8N1-style frame (start, data LSB-first, stop).
- It sits between the TX FIFO and the top-level tx pin.
- The matching receiver writes into the RX FIFO on the far end of the link.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200). Legal range >= 2.
- DATA_BITS, 8, word width; must match FIFO DATA_BITS.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- enable  input  1  allow new frames to start; level-sensitive
- fifo_dout  input  DATA_BITS  FIFO dequeue data; valid the cycle after fifo_rd_req
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_req  output  1  FIFO dequeue request; one-cycle pulse per word
- tx  output  1  serial line; idle high
- busy  output  1  high whenever state != IDLE
- tx_done  output  1  one-cycle pulse on the last clk of the final stop bit

Behaviour:
- Clock, reset and widths
  - Clock clk. Reset reset, synchronous, active-high.
  - Reset values: tx=1, fifo_rd_req=0, busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
  - Baud counter width is $clog2(CLKS_PER_BIT). Bit index width is $clog2(DATA_BITS+1).
- States: IDLE, REQ, LOAD, START, DATA, [PARITY], STOP.
- IDLE
  - If enable=1 and fifo_empty=0 (sampled at the edge), go to REQ; otherwise stay.
  - tx=1.
- REQ
  - Exactly one cycle. fifo_rd_req=1 only in this state.
  - Next state is LOAD.
- LOAD
  - Exactly one cycle. Capture fifo_dout into the shift register; this is the FIFO's registered dequeue output.
  - Next state is START. Baud counter is cleared.
- START
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA
  - tx = shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the index.
  - After DATA_BITS bits, go to PARITY (if compiled in) or STOP.
- STOP
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 on the final cycle.
  - Exit: if enable=1 and fifo_empty=0 on that cycle, go directly to REQ (back-to-back). Otherwise go to IDLE.
- Inter-frame gap: back-to-back frames carry exactly 2 idle-high cycles (REQ, LOAD) between the stop bit end and the next start bit.
- Latency: fifo_empty falling at edge N (in IDLE) gives fifo_rd_req high at cycle N+1, data captured at N+2, and tx falling at N+3.
- enable deasserted mid-frame: the current frame completes unchanged and no new request is issued.
- fifo_empty is ignored outside IDLE and the STOP exit cycle. In REQ the FIFO is guaranteed non-empty because this block is the sole reader.
- Reset mid-frame:
  - tx returns to 1 and state to IDLE on the next edge.
  - A word already dequeued is discarded and not retransmitted.
  - No glitch pulse appears on fifo_rd_req.
- tx is registered (driven from a flop) so there are no combinational glitches on the pin.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP.
  - tx carries the even-parity bit (XOR of the captured word) for CLKS_PER_BIT cycles.
  - Frame length becomes 1+DATA_BITS+1+STOP_BITS bits.
- Undefined: no PARITY state and no parity logic; DATA goes straight to STOP.

Test Plan:
- All cases use CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1.
- Single byte: FIFO holds 0xA5, enable=1. Expect:
  - fifo_rd_req one-cycle pulse, then tx=0 for 4 cycles.
  - tx bits 1,0,1,0,0,1,0,1 at 4 cycles each, then tx=1 for 4 cycles.
  - tx_done pulses once on the last stop cycle; busy returns to 0.
- Back-to-back: FIFO holds 0x01, 0xFF. Expect:
  - Two frames with exactly 2 high cycles between the end of stop and the second start.
  - fifo_rd_req pulses exactly twice; FIFO empty after the second request.
- Empty FIFO / disabled: fifo_empty=1 for 100 cycles, then fifo_empty=0 with enable=0 for 100 cycles. Expect tx=1, busy=0, and fifo_rd_req=0 throughout.
- Enable drop mid-frame: deassert enable during DATA bit 3 with 2 words queued. Expect:
  - The first frame completes fully; no second fifo_rd_req; state IDLE.
  - The second word remains in the FIFO.
- Reset mid-frame: assert reset during DATA bit 5 of 0x3C. Expect:
  - Next edge tx=1, busy=0, tx_done=0.
  - After release with an empty FIFO, no frame is sent.
- Parity (UART_TX_PARITY_EN defined): send 0x07. Expect:
  - Parity bit 1 for 4 cycles before the stop bit.
  - Total frame 44 cycles; tx_done on cycle 44.
